// File: rtl/ready_latch_pkg.sv
// Shared state encoding, default timing constants and counter-width helper
// for the multi-player ready/number latch.
package ready_latch_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    LATCHED = 2'd2
  } state_t;

  localparam int DEF_TICK_DIV     = 50_000_000;
  localparam int DEF_DEBOUNCE_CYC = 1_000_000;

  // Bits needed for a counter that runs 0..n-1 (never less than one bit).
  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/ready_debounce.sv
// Single-bit 2-FF synchroniser followed by a debouncer that only changes its
// level after DEBOUNCE_CYC consecutive disagreeing synced samples.
module ready_debounce
  import ready_latch_pkg::*;
#(
  parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_raw,
  output logic o_level
);

  localparam int CW = cnt_width(DEBOUNCE_CYC);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_level;
  logic [CW-1:0] r_cnt;

  // Any agreeing sample restarts the run, so only an unbroken disagreement flips the level.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_level <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
      if (r_sync2 != r_level) begin
        if (r_cnt == CW'(DEBOUNCE_CYC - 1)) begin
          r_level <= r_sync2;
          r_cnt   <= '0;
        end else begin
          r_cnt <= r_cnt + CW'(1);
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign o_level = r_level;

endmodule

// File: rtl/ready_latch_multi.sv
// N-player game-start block: debounced READY buttons, free-running slow modulo
// counter, and a state machine that latches the counter as the game number.
module ready_latch_multi
  import ready_latch_pkg::*;
#(
  parameter int N_PLAYERS    = 2,
  parameter int TICK_DIV     = DEF_TICK_DIV,
  parameter int NUM_MOD      = 10,
  parameter int NUM_W        = 4,
  parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [N_PLAYERS-1:0] i_ready,
  input  logic [N_PLAYERS-1:0] i_player_en,
  input  logic                 i_clr,
  output logic [NUM_W-1:0]     o_num,
  output logic                 o_num_valid,
  output logic                 o_run_in,
  output logic                 o_abort,
  output logic [N_PLAYERS-1:0] o_rdy_db
);

  localparam int PW = cnt_width(TICK_DIV);

  if (NUM_MOD < 2 || NUM_MOD > 2**NUM_W) begin : g_bad_num_mod
    $error("ready_latch_multi: NUM_MOD must lie in 2..2**NUM_W");
  end
  if (N_PLAYERS < 1 || N_PLAYERS > 8) begin : g_bad_players
    $error("ready_latch_multi: N_PLAYERS must lie in 1..8");
  end

  logic [N_PLAYERS-1:0] w_rdy_db;
  logic [N_PLAYERS-1:0] r_db_prev;
  logic [PW-1:0]        r_presc;
  logic [NUM_W-1:0]     r_count;
  state_t               r_state;
  logic                 w_tick;
  logic                 w_all_ready;
  logic                 w_none_ready;
  logic                 w_fell;

  for (genvar gi = 0; gi < N_PLAYERS; gi++) begin : g_db
    ready_debounce #(
      .DEBOUNCE_CYC(DEBOUNCE_CYC)
    ) u_db (
      .i_clk  (i_clk),
      .i_rst  (i_rst),
      .i_raw  (i_ready[gi]),
      .o_level(w_rdy_db[gi])
    );
  end

  // Disabled players count as ready, but an all-zero mask must never trigger.
  assign w_all_ready  = (i_player_en != '0) && (&(w_rdy_db | ~i_player_en));
  assign w_none_ready = ((w_rdy_db & i_player_en) == '0);
  assign w_fell       = |(r_db_prev & ~w_rdy_db & i_player_en);
  assign w_tick       = (r_presc == PW'(TICK_DIV - 1));
  assign o_rdy_db     = w_rdy_db;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_presc   <= '0;
      r_count   <= '0;
      r_db_prev <= '0;
    end else begin
      r_db_prev <= w_rdy_db;
      if (w_tick) begin
        r_presc <= '0;
        r_count <= (r_count == NUM_W'(NUM_MOD - 1)) ? '0 : r_count + NUM_W'(1);
      end else begin
        r_presc <= r_presc + PW'(1);
      end
    end
  end

  // Clear wins over every transition, including a capture in the same cycle.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= IDLE;
      o_num       <= '0;
      o_num_valid <= 1'b0;
      o_run_in    <= 1'b0;
      o_abort     <= 1'b0;
    end else begin
      o_num_valid <= 1'b0;
      o_abort     <= 1'b0;
      if (i_clr) begin
        r_state  <= IDLE;
        o_run_in <= 1'b0;
      end else begin
        case (r_state)
          IDLE: begin
            if (w_none_ready) r_state <= ARMED;
          end
          ARMED: begin
            if (w_all_ready) begin
              r_state     <= LATCHED;
              o_num       <= r_count;
              o_num_valid <= 1'b1;
              o_run_in    <= 1'b1;
            end
          end
          LATCHED: begin
            if (w_fell) begin
              r_state  <= IDLE;
              o_run_in <= 1'b0;
              o_abort  <= 1'b1;
            end
          end
          default: begin
            r_state  <= IDLE;
            o_run_in <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ready_latch_multi.sv
// Self-checking bench for ready_latch_multi: directed phases plus a random
// phase, all compared cycle by cycle against a behavioural reference model.
module tb_ready_latch_multi;

  localparam int NP  = 2;
  localparam int TD  = 4;
  localparam int NM  = 10;
  localparam int NW  = 4;
  localparam int DC  = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [NP-1:0] ready = '0;
  logic [NP-1:0] en = '0;
  logic          clr = 1'b0;
  logic [NW-1:0] num;
  logic          numValid;
  logic          runIn;
  logic          abortP;
  logic [NP-1:0] rdyDb;

  int testsRun = 0;
  int failCount = 0;

  // Reference model state: edge count since reset release and sampled raw history.
  int            mdlEdges;
  logic [NP-1:0] rawQ[$];
  logic [NP-1:0] mdlDb;
  logic [NP-1:0] mdlDbPrev;
  int            mdlState;
  logic [NW-1:0] mdlNum;
  logic          mdlNv;
  logic          mdlAb;

  ready_latch_multi #(
    .N_PLAYERS(NP), .TICK_DIV(TD), .NUM_MOD(NM), .NUM_W(NW), .DEBOUNCE_CYC(DC)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_ready(ready), .i_player_en(en), .i_clr(clr),
    .o_num(num), .o_num_valid(numValid), .o_run_in(runIn), .o_abort(abortP),
    .o_rdy_db(rdyDb)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testsRun++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic syncBefore(input int e, input int p);
    if (e - 2 < 1) return 1'b0;
    return rawQ[e-3][p];
  endfunction

  function automatic logic allReadyM(input logic [NP-1:0] db, input logic [NP-1:0] m);
    return (m != '0) && ((db | ~m) == '1);
  endfunction

  task automatic modelReset();
    mdlEdges = 0;
    rawQ.delete();
    mdlDb = '0;
    mdlDbPrev = '0;
    mdlState = 0;
    mdlNum = '0;
    mdlNv = 1'b0;
    mdlAb = 1'b0;
  endtask

  // One clock edge of the reference model, using the inputs present at that edge.
  task automatic modelEdge();
    logic [NW-1:0] cntBefore;
    logic          flip;
    mdlEdges++;
    rawQ.push_back(ready);
    cntBefore = NW'(((mdlEdges - 1) / TD) % NM);
    mdlNv = 1'b0;
    mdlAb = 1'b0;
    if (clr) begin
      mdlState = 0;
    end else if (mdlState == 0) begin
      if ((mdlDb & en) == '0) mdlState = 1;
    end else if (mdlState == 1) begin
      if (allReadyM(mdlDb, en)) begin
        mdlState = 2;
        mdlNum = cntBefore;
        mdlNv = 1'b1;
      end
    end else begin
      if ((mdlDbPrev & ~mdlDb & en) != '0) begin
        mdlState = 0;
        mdlAb = 1'b1;
      end
    end
    mdlDbPrev = mdlDb;
    for (int p = 0; p < NP; p++) begin
      flip = 1'b1;
      for (int j = 0; j < DC; j++)
        if (syncBefore(mdlEdges - j, p) == mdlDb[p]) flip = 1'b0;
      if (flip) mdlDb[p] = ~mdlDb[p];
    end
  endtask

  task automatic stepCycle();
    @(posedge clk);
    modelEdge();
    #1;
    checkOutput("rdy_db", 32'(rdyDb), 32'(mdlDb));
    checkOutput("num_valid", 32'(numValid), 32'(mdlNv));
    checkOutput("run_in", 32'(runIn), 32'(mdlState == 2));
    checkOutput("abort", 32'(abortP), 32'(mdlAb));
    checkOutput("num", 32'(num), 32'(mdlNum));
  endtask

  task automatic applyStimulus(input int n);
    for (int k = 0; k < n; k++) stepCycle();
  endtask

  task automatic applyReset();
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    modelReset();
    checkOutput("rst_num", 32'(num), 32'd0);
    checkOutput("rst_num_valid", 32'(numValid), 32'd0);
    checkOutput("rst_run_in", 32'(runIn), 32'd0);
    checkOutput("rst_abort", 32'(abortP), 32'd0);
    checkOutput("rst_rdy_db", 32'(rdyDb), 32'd0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic          hit;
    logic [NW-1:0] savedNum;

    // Reset, then reset again mid-count with buttons active.
    applyReset();
    en = 2'b11;
    ready = 2'b01;
    applyStimulus(25);
    applyReset();
    ready = 2'b00;
    applyStimulus(45);

    // Normal two-player start.
    ready = 2'b01;
    applyStimulus(20);
    ready = 2'b11;
    applyStimulus(10);

    // Release (abort), then bouncing on player 0.
    ready = 2'b00;
    applyStimulus(10);
    for (int r = 0; r < 8; r++) begin
      ready[0] = 1'b1;
      applyStimulus(2);
      ready[0] = 1'b0;
      applyStimulus(1);
    end
    applyStimulus(6);

    // Capture, abort by player 1, re-press while player 0 still held, then full re-arm.
    ready = 2'b11;
    applyStimulus(10);
    ready = 2'b01;
    applyStimulus(8);
    ready = 2'b11;
    applyStimulus(10);
    ready = 2'b00;
    applyStimulus(8);
    ready = 2'b11;
    applyStimulus(10);

    // Single player, then no players enabled.
    ready = 2'b00;
    applyStimulus(8);
    en = 2'b01;
    ready = 2'b01;
    applyStimulus(8);
    ready = 2'b11;
    applyStimulus(6);
    ready = 2'b01;
    applyStimulus(6);
    en = 2'b00;
    ready = 2'b00;
    applyStimulus(8);
    ready = 2'b11;
    applyStimulus(10);

    // Clear arriving in the same cycle as all_ready while armed.
    ready = 2'b00;
    en = 2'b11;
    applyStimulus(8);
    ready = 2'b11;
    hit = 1'b0;
    for (int k = 0; k < 20 && !hit; k++) begin
      if (mdlState == 1 && allReadyM(mdlDb, en)) begin
        clr = 1'b1;
        hit = 1'b1;
      end else begin
        stepCycle();
      end
    end
    testsRun++;
    assert (hit) else begin
      failCount++;
      $error("[TB] FAIL clr_setup observed=%0d expected=%0d", hit, 1);
    end
    savedNum = mdlNum;
    stepCycle();
    clr = 1'b0;
    checkOutput("clr_no_valid", 32'(numValid), 32'd0);
    checkOutput("clr_num_kept", 32'(num), 32'(savedNum));
    checkOutput("clr_run_in", 32'(runIn), 32'd0);
    applyStimulus(4);

    // Capture on a tick edge while the counter holds 9.
    en = 2'b00;
    ready = 2'b01;
    hit = 1'b0;
    for (int k = 0; k < 30 && !hit; k++) begin
      if (mdlState == 1 && mdlDb[0]) hit = 1'b1;
      else stepCycle();
    end
    testsRun++;
    assert (hit) else begin
      failCount++;
      $error("[TB] FAIL tick9_armed observed=%0d expected=%0d", hit, 1);
    end
    hit = 1'b0;
    for (int k = 0; k < 100 && !hit; k++) begin
      if (mdlEdges % (TD * NM) == TD * NM - 1) begin
        en = 2'b01;
        hit = 1'b1;
      end else begin
        stepCycle();
      end
    end
    stepCycle();
    checkOutput("tick9_num", 32'(num), 32'd9);
    checkOutput("tick9_valid", 32'(numValid), 32'd1);
    applyStimulus(4);

    // Random phase.
    en = 2'b11;
    for (int k = 0; k < 400; k++) begin
      for (int p = 0; p < NP; p++)
        if ($urandom_range(5) == 0) ready[p] = ~ready[p];
      if ($urandom_range(59) == 0) en = NP'($urandom_range(3));
      clr = ($urandom_range(39) == 0);
      stepCycle();
    end
    clr = 1'b0;

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
